// File: rtl/param_mpu_pkg.sv
// Shared opcodes, FSM state type and flag bit positions for param_microprocessor.
// Pure declarations: no latency, no flow control.
package param_mpu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_MOV = 4'd10;
  localparam logic [3:0] OP_LDI = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [3:0] OP_CMP = 4'd13;
  localparam logic [3:0] OP_NOP = 4'd14;
  localparam logic [3:0] OP_ILL = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_W     = 3;

endpackage

// File: rtl/mpu_regfile.sv
// NUM_REGS x DATA_W register file: two combinational read ports, one synchronous write port.
// Reads are zero-latency, writes land on the clock edge; no flow control.
module mpu_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(NUM_REGS)-1:0] rd_sel1,
  input  logic [$clog2(NUM_REGS)-1:0] rd_sel2,
  output logic [DATA_W-1:0]           rd_dat1,
  output logic [DATA_W-1:0]           rd_dat2,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_sel,
  input  logic [DATA_W-1:0]           wr_dat
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_sel] <= wr_dat;
    end
  end

  assign rd_dat1 = regs[rd_sel1];
  assign rd_dat2 = regs[rd_sel2];

endmodule

// File: rtl/param_microprocessor.sv
// Register-file + ALU core with registered result/flags; PARAM_MPU_MUL_EN adds an iterative shift-add multiplier.
// Latency 1 (MUL: DATA_W cycles); instr_ready drops only while a multiply is in flight.
module param_microprocessor
  import param_mpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instruction,
  input  logic [SEL_W-1:0]  read_sel1,
  input  logic [SEL_W-1:0]  read_sel2,
  input  logic [SEL_W-1:0]  write_sel,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              ovf_flag,
  output logic              illegal
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] op_a, op_b;
  logic              rf_wr_en;
  logic [SEL_W-1:0]  rf_wr_sel;
  logic [DATA_W-1:0] rf_wr_dat;
  logic              accept;
  logic [FLG_W-1:0]  flags;

  logic [DATA_W-1:0] alu_res;
  logic [DATA_W:0]   sum_w, dif_w;
  logic              alu_c, alu_v, alu_wr, alu_upd, alu_res_upd, op_illegal;

  mpu_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (reset),
    .rd_sel1 (read_sel1),
    .rd_sel2 (read_sel2),
    .rd_dat1 (op_a),
    .rd_dat2 (op_b),
    .wr_en   (rf_wr_en),
    .wr_sel  (rf_wr_sel),
    .wr_dat  (rf_wr_dat)
  );

  assign accept = instr_valid && instr_ready;

`ifdef PARAM_MPU_MUL_EN
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  state_t              state, state_nxt;
  logic                mul_start, mul_done;
  logic [CNT_W-1:0]    mul_cnt;
  logic [2*DATA_W-1:0] mul_acc, mul_mcand, mul_sum;
  logic [DATA_W-1:0]   mul_mplier;
  logic [SEL_W-1:0]    mul_wsel;
`endif

  always_comb begin
    sum_w       = {1'b0, op_a} + {1'b0, op_b};
    dif_w       = {1'b0, op_a} - {1'b0, op_b};
    alu_res     = '0;
    alu_c       = 1'b0;
    alu_v       = 1'b0;
    alu_wr      = 1'b1;
    alu_res_upd = 1'b1;
    alu_upd     = 1'b1;
    op_illegal  = 1'b0;
`ifdef PARAM_MPU_MUL_EN
    mul_start   = 1'b0;
`endif
    case (instruction)
      OP_ADD: begin
        alu_res = sum_w[MSB:0];
        alu_c   = sum_w[DATA_W];
        alu_v   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = dif_w[MSB:0];
        alu_c   = dif_w[DATA_W];
        alu_v   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
        if (instruction == OP_CMP) begin
          alu_wr      = 1'b0;
          alu_res_upd = 1'b0;
        end
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_NOT: alu_res = ~op_a;
      OP_SHL: begin
        alu_res = op_a << 1;
        alu_c   = op_a[MSB];
      end
      OP_SHR: begin
        alu_res = op_a >> 1;
        alu_c   = op_a[0];
      end
      OP_INC: begin
        alu_res = op_a + 1'b1;
        alu_c   = &op_a;
        alu_v   = ~op_a[MSB] & alu_res[MSB];
      end
      OP_DEC: begin
        alu_res = op_a - 1'b1;
        alu_c   = ~|op_a;
        alu_v   = op_a[MSB] & ~alu_res[MSB];
      end
      OP_MOV: alu_res = op_a;
      OP_LDI: alu_res = imm;
`ifdef PARAM_MPU_MUL_EN
      OP_MUL: begin
        alu_wr      = 1'b0;
        alu_res_upd = 1'b0;
        alu_upd     = 1'b0;
        mul_start   = 1'b1;
      end
`endif
      OP_NOP: begin
        alu_wr      = 1'b0;
        alu_res_upd = 1'b0;
        alu_upd     = 1'b0;
      end
      default: begin
        alu_wr      = 1'b0;
        alu_res_upd = 1'b0;
        alu_upd     = 1'b0;
        op_illegal  = 1'b1;
      end
    endcase
  end

`ifdef PARAM_MPU_MUL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && mul_start) state_nxt = ST_MUL;
      ST_MUL:  if (mul_cnt == CNT_W'(DATA_W - 1)) state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = reset && (state == ST_IDLE);
    mul_done    = (state == ST_MUL) && (mul_cnt == CNT_W'(DATA_W - 1));
  end

  // One partial product per cycle; the final step's sum is the product itself.
  assign mul_sum = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
      mul_wsel   <= '0;
    end else if (accept && mul_start) begin
      mul_acc    <= '0;
      mul_mcand  <= {{DATA_W{1'b0}}, op_a};
      mul_mplier <= op_b;
      mul_cnt    <= '0;
      mul_wsel   <= write_sel;
    end else if (state == ST_MUL) begin
      mul_acc    <= mul_sum;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + 1'b1;
    end
  end
`else
  assign instr_ready = reset;
`endif

  always_comb begin
    rf_wr_en  = accept && alu_wr;
    rf_wr_sel = write_sel;
    rf_wr_dat = alu_res;
`ifdef PARAM_MPU_MUL_EN
    if (mul_done) begin
      rf_wr_en  = 1'b1;
      rf_wr_sel = mul_wsel;
      rf_wr_dat = mul_sum[MSB:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result       <= '0;
      flags        <= '0;
      result_valid <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (accept && op_illegal) illegal <= 1'b1;
      if (accept && alu_upd) begin
        flags[FLG_ZERO]  <= (alu_res == '0);
        flags[FLG_CARRY] <= alu_c;
        flags[FLG_OVF]   <= alu_v;
        result_valid     <= 1'b1;
        if (alu_res_upd) result <= alu_res;
      end
`ifdef PARAM_MPU_MUL_EN
      if (mul_done) begin
        result           <= mul_sum[MSB:0];
        flags[FLG_ZERO]  <= (mul_sum[MSB:0] == '0);
        flags[FLG_CARRY] <= |mul_sum[2*DATA_W-1:DATA_W];
        flags[FLG_OVF]   <= 1'b0;
        result_valid     <= 1'b1;
      end
`endif
    end
  end

  assign zero_flag  = flags[FLG_ZERO];
  assign carry_flag = flags[FLG_CARRY];
  assign ovf_flag   = flags[FLG_OVF];

endmodule

// File: tb/tb_param_microprocessor.sv
// Directed bench for param_microprocessor (DATA_W=8, NUM_REGS=4); register contents observed via MOV rX->rX.
module tb_param_microprocessor;
  import param_mpu_pkg::*;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instruction;
  logic [SEL_W-1:0]  read_sel1, read_sel2, write_sel;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] result;
  logic              result_valid, zero_flag, carry_flag, ovf_flag, illegal;

  int n_chk = 0;
  int n_err = 0;

  param_microprocessor #(.DATA_W(DATA_W), .NUM_REGS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instruction  (instruction),
    .read_sel1    (read_sel1),
    .read_sel2    (read_sel2),
    .write_sel    (write_sel),
    .imm          (imm),
    .result       (result),
    .result_valid (result_valid),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag),
    .ovf_flag     (ovf_flag),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input int z, input int c, input int v);
    chk({tag, "_zero"},  int'(zero_flag),  z);
    chk({tag, "_carry"}, int'(carry_flag), c);
    chk({tag, "_ovf"},   int'(ovf_flag),   v);
  endtask

  // Present one instruction, wait for the accept edge, return #1 after it.
  task automatic exec(input int op, input int s1, input int s2, input int ws, input int im);
    instruction = 4'(op);
    read_sel1   = SEL_W'(s1);
    read_sel2   = SEL_W'(s2);
    write_sel   = SEL_W'(ws);
    imm         = DATA_W'(im);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input int exp);
    chk({tag, "_rv"},  int'(result_valid), 1);
    chk({tag, "_res"}, int'(result), exp);
  endtask

  task automatic wait_mul(output int lat);
    lat = 0;
    while (!result_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int inc_res [4] = '{'hFF, 'h00, 'h01, 'h02};
    int inc_c   [4] = '{0, 1, 0, 0};
    int inc_z   [4] = '{0, 1, 0, 0};
    int lat;
    int rv_cnt;

    reset = 1'b0;
    instr_valid = 1'b0;
    instruction = '0;
    read_sel1 = '0;
    read_sel2 = '0;
    write_sel = '0;
    imm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(instr_ready), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_rv", int'(result_valid), 0);
    chk("rst_illegal", int'(illegal), 0);
    chk_flags("rst", 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("rel_ready", int'(instr_ready), 1);

    exec(OP_LDI, 0, 0, 0, 'h7F);  chk_res("ldi7f", 'h7F);
    exec(OP_LDI, 0, 0, 1, 'h01);  chk_res("ldi01", 'h01);
    exec(OP_ADD, 0, 1, 2, 0);     chk_res("add", 'h80);  chk_flags("add", 0, 0, 1);
    exec(OP_MOV, 2, 0, 2, 0);     chk_res("r2", 'h80);   chk_flags("mov", 0, 0, 0);
    exec(OP_LDI, 0, 0, 3, 'h00);  chk_res("ldi00", 'h00); chk_flags("ldi00", 1, 0, 0);
    exec(OP_SUB, 3, 1, 0, 0);     chk_res("sub", 'hFF);  chk_flags("sub", 0, 1, 0);
    exec(OP_CMP, 1, 1, 0, 0);     chk_res("cmp", 'hFF);  chk_flags("cmp", 1, 0, 0);
    exec(OP_MOV, 0, 0, 0, 0);     chk_res("r0_after_cmp", 'hFF);

    exec(OP_LDI, 0, 0, 0, 'hFE);
    for (int i = 0; i < 4; i++) begin
      chk("inc_ready", int'(instr_ready), 1);
      exec(OP_INC, 0, 0, 0, 0);
      chk_res("inc", inc_res[i]);
      chk_flags("inc", inc_z[i], inc_c[i], 0);
    end

    exec(OP_NOP, 0, 0, 1, 0);
    chk("nop_rv", int'(result_valid), 0);
    chk("nop_res", int'(result), 'h02);
    exec(OP_MOV, 1, 0, 1, 0);     chk_res("r1_after_nop", 'h01);

`ifdef PARAM_MPU_MUL_EN
    exec(OP_LDI, 0, 0, 0, 'h10);
    exec(OP_LDI, 0, 0, 1, 'h20);
    exec(OP_MUL, 0, 1, 2, 0);
    chk("mul_ready", int'(instr_ready), 0);
    chk("mul_rv_early", int'(result_valid), 0);
    // A competing LDI held during the multiply must be neither accepted nor steer the writeback.
    instruction = OP_LDI; write_sel = 2'd3; read_sel1 = 2'd3; imm = 8'hAA; instr_valid = 1'b1;
    wait_mul(lat);
    instr_valid = 1'b0;
    chk("mul_lat", lat, 8);
    chk("mul_res", int'(result), 'h00);
    chk_flags("mul", 1, 1, 0);
    chk("mul_ready_after", int'(instr_ready), 1);
    exec(OP_MOV, 2, 0, 2, 0);     chk_res("r2_mul", 'h00);
    exec(OP_MOV, 3, 0, 3, 0);     chk_res("r3_untouched", 'h00);

    exec(OP_LDI, 0, 0, 0, 'h03);
    exec(OP_LDI, 0, 0, 1, 'h05);
    exec(OP_MUL, 0, 1, 3, 0);
    wait_mul(lat);
    chk("mul2_lat", lat, 8);
    chk("mul2_res", int'(result), 'h0F);
    chk_flags("mul2", 0, 0, 0);
    exec(OP_MOV, 3, 0, 3, 0);     chk_res("r3_mul", 'h0F);

    exec(OP_MUL, 0, 1, 2, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_ready", int'(instr_ready), 0);
    chk("abort_res", int'(result), 0);
    chk("abort_rv", int'(result_valid), 0);
    chk_flags("abort", 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    rv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) rv_cnt++;
    end
    chk("abort_no_rv", rv_cnt, 0);
    chk("abort_ready_rel", int'(instr_ready), 1);
    exec(OP_MOV, 3, 0, 3, 0);     chk_res("r3_cleared", 'h00);
    exec(OP_MOV, 0, 0, 0, 0);     chk_res("r0_cleared", 'h00);
`else
    chk("op12_pre_illegal", int'(illegal), 0);
    exec(OP_MUL, 0, 1, 2, 0);
    chk("op12_illegal", int'(illegal), 1);
    chk("op12_rv", int'(result_valid), 0);
    chk("op12_ready", int'(instr_ready), 1);
    chk("op12_res", int'(result), 'h01);
    exec(OP_MOV, 2, 0, 2, 0);     chk_res("r2_after_op12", 'h80);
    reset = 1'b0;
    #1;
    chk("rst2_illegal", int'(illegal), 0);
    chk("rst2_ready", int'(instr_ready), 0);
    chk("rst2_res", int'(result), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exec(OP_MOV, 2, 0, 2, 0);     chk_res("r2_cleared", 'h00);
`endif

    exec(OP_LDI, 0, 0, 1, 'h81);  chk_res("ldi81", 'h81);
    exec(OP_ILL, 0, 0, 1, 0);
    chk("ill_flag", int'(illegal), 1);
    chk("ill_rv", int'(result_valid), 0);
    chk("ill_res", int'(result), 'h81);
    exec(OP_MOV, 1, 0, 1, 0);     chk_res("r1_after_ill", 'h81);
    chk("ill_sticky", int'(illegal), 1);

    exec(OP_LDI, 0, 0, 3, 'h80);
    exec(OP_DEC, 3, 0, 3, 0);     chk_res("dec80", 'h7F); chk_flags("dec80", 0, 0, 1);
    exec(OP_SHL, 1, 0, 2, 0);     chk_res("shl", 'h02);   chk_flags("shl", 0, 1, 0);
    exec(OP_SHR, 1, 0, 0, 0);     chk_res("shr", 'h40);   chk_flags("shr", 0, 1, 0);
    exec(OP_AND, 1, 3, 0, 0);     chk_res("and", 'h01);
    exec(OP_OR,  1, 3, 0, 0);     chk_res("or",  'hFF);
    exec(OP_XOR, 1, 3, 0, 0);     chk_res("xor", 'hFE);
    exec(OP_NOT, 1, 0, 0, 0);     chk_res("not", 'h7E);   chk_flags("not", 0, 0, 0);
    exec(OP_SUB, 3, 1, 0, 0);     chk_res("sub_ovf", 'hFE); chk_flags("sub_ovf", 0, 1, 1);
    exec(OP_LDI, 0, 0, 2, 'h00);
    exec(OP_DEC, 2, 0, 2, 0);     chk_res("dec00", 'hFF); chk_flags("dec00", 0, 1, 0);
    exec(OP_ADD, 1, 1, 0, 0);     chk_res("add_c", 'h02); chk_flags("add_c", 0, 1, 1);
    chk("ill_end", int'(illegal), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
